// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and helpers for the mux select sequencer: FSM encoding and
// select-sweep end points.
package mux_sel_sequencer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   function automatic int unsigned sel_first(input int unsigned width, input bit msb_first);
      return msb_first ? width - 1 : 0;
   endfunction

   function automatic int unsigned sel_last(input int unsigned width, input bit msb_first);
      return msb_first ? 0 : width - 1;
   endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Select counter: sweeps sel from FIRST to LAST one step per strobe and is
// reloaded to FIRST, so it never wraps.
module mux_sel_counter
   import mux_sel_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MSB_FIRST = 1,
   localparam int unsigned SEL_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   output logic [SEL_W-1:0] sel,
   output logic             is_last
);

   localparam logic [SEL_W-1:0] FIRST = SEL_W'(sel_first(WIDTH, MSB_FIRST != 0));
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(sel_last(WIDTH, MSB_FIRST != 0));

   logic [SEL_W-1:0] r_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sel <= FIRST;
      else if (load)
         r_sel <= FIRST;
      else if (step)
         r_sel <= (MSB_FIRST != 0) ? r_sel - 1'b1 : r_sel + 1'b1;
   end

   assign sel     = r_sel;
   assign is_last = (r_sel == LAST);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Loads a word onto an external WIDTH:1 mux and streams its output bit per
// select position, with valid/ready on both sides and zero-bubble reload.
module mux_sel_sequencer
   import mux_sel_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MSB_FIRST = 1,
   localparam int unsigned SEL_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] mux_a,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_last,
   output logic             busy
);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [WIDTH-1:0] r_mux_a;
   logic             w_is_last;
   logic             w_in_acc;
   logic             w_out_xfer;
   logic             w_load;
   logic             w_step;
   logic             w_in_ready;

   assign w_in_acc   = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;
   assign w_load     = w_in_acc || (w_out_xfer && w_is_last);
   assign w_step     = w_out_xfer && !w_is_last;

   mux_sel_counter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (w_load),
      .step    (w_step),
      .sel     (mux_sel),
      .is_last (w_is_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_in_acc) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (w_out_xfer && w_is_last) w_state_nxt = w_in_acc ? ST_SHIFT : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // The LAST beat opens the input so the next word lands with no bubble.
   always_comb begin
      out_valid  = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE: w_in_ready = 1'b1;
         ST_SHIFT: begin
            out_valid  = 1'b1;
            out_last   = w_is_last;
            busy       = 1'b1;
            w_in_ready = w_is_last && out_ready;
         end
         default: ;
      endcase
   end

   assign in_ready = rst_n && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mux_a <= '0;
      else if (w_in_acc)
         r_mux_a <= in_data;
   end

   assign mux_a   = r_mux_a;
   assign out_bit = mux_y;

endmodule
